// File: rtl/cps_normalizer.sv
// Cross-power-spectrum stage: F1*conj(F2) per bin, normalised either by a
// constant arithmetic shift or by division by the L1 magnitude.
module cps_normalizer #(
  parameter int unsigned W         = 16,
  parameter int unsigned OW        = 16,
  parameter int unsigned SHIFT     = 18,
  parameter int unsigned FRAC      = 14,
  parameter int unsigned LOG2_BINS = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        mode,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic signed [W-1:0]         x1,
  input  logic signed [W-1:0]         y1,
  input  logic signed [W-1:0]         x2,
  input  logic signed [W-1:0]         y2,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [OW-1:0]        xf,
  output logic signed [OW-1:0]        yf,
  output logic [LOG2_BINS-1:0]        out_bin,
  output logic                        out_last,
  output logic                        out_sat,
  output logic                        out_zero
);

  localparam int unsigned PW  = 2 * W + 1;
  localparam int unsigned MW  = 2 * W + 2;
  localparam int unsigned RW  = 2 * W + 3;
  localparam int unsigned QW  = FRAC + 1;
  localparam int unsigned CW  = $clog2(FRAC + 1);
  localparam int unsigned AW0 = (RW > QW + 1) ? RW : QW + 1;
  localparam int unsigned AW  = (AW0 > OW + 1) ? AW0 : OW + 1;

  localparam logic signed [AW-1:0] OMAX = AW'({1'b0, {(OW-1){1'b1}}});
  localparam logic signed [AW-1:0] OMIN = ~OMAX;

  typedef enum logic [2:0] {IDLE, MUL, MAG, DIV, OUT} state_t;

  state_t state, state_n;

  logic signed [W-1:0]  x1_r, y1_r, x2_r, y2_r, x1_n, y1_n, x2_n, y2_n;
  logic                 mode_r, mode_n;
  logic signed [PW-1:0] re_r, im_r, re_n, im_n, re_c, im_c;
  logic [MW-1:0]        mag_r, mag_n, re_abs, im_abs, mag_c;
  logic signed [MW-1:0] re_w, im_w;
  logic                 neg_re, neg_im, neg_re_n, neg_im_n;
  logic [RW-1:0]        rem_re, rem_im, rem_re_n, rem_im_n, mag_ext;
  logic [RW-1:0]        rem_re_step, rem_im_step;
  logic                 re_ge, im_ge;
  logic [QW-1:0]        q_re, q_im, q_re_n, q_im_n, q_re_next, q_im_next;
  logic signed [AW-1:0] qx_s, qy_s;
  logic [CW-1:0]        cnt, cnt_n;
  logic [OW:0]          sh_x, sh_y, dv_x, dv_y;
  logic signed [OW-1:0] xf_n, yf_n;
  logic                 sat_n, zero_n, last_n, valid_n, ready_n;
  logic [LOG2_BINS-1:0] bin_n, bin_inc;

  // Clip a wide signed value to OW bits; MSB of the result flags clipping.
  function automatic logic [OW:0] clip(input logic signed [AW-1:0] v);
    if (v > OMAX) return {1'b1, OMAX[OW-1:0]};
    if (v < OMIN) return {1'b1, OMIN[OW-1:0]};
    return {1'b0, v[OW-1:0]};
  endfunction

  // Full-width complex products of the latched bin.
  assign re_c = PW'(x1_r) * PW'(x2_r) + PW'(y1_r) * PW'(y2_r);
  assign im_c = PW'(y1_r) * PW'(x2_r) - PW'(x1_r) * PW'(y2_r);

  // Constant-shift results, saturated.
  assign sh_x = clip(AW'(re_c >>> SHIFT));
  assign sh_y = clip(AW'(im_c >>> SHIFT));

  // L1 magnitude of the registered products.
  assign re_w   = MW'(re_r);
  assign im_w   = MW'(im_r);
  assign re_abs = re_w[MW-1] ? -re_w : re_w;
  assign im_abs = im_w[MW-1] ? -im_w : im_w;
  assign mag_c  = re_abs + im_abs;

  // One restoring-division step per component.
  assign mag_ext     = RW'(mag_r);
  assign re_ge       = rem_re >= mag_ext;
  assign im_ge       = rem_im >= mag_ext;
  assign rem_re_step = re_ge ? rem_re - mag_ext : rem_re;
  assign rem_im_step = im_ge ? rem_im - mag_ext : rem_im;
  assign q_re_next   = {q_re[QW-2:0], re_ge};
  assign q_im_next   = {q_im[QW-2:0], im_ge};

  // Final quotients with the product signs applied, saturated.
  assign qx_s = AW'(q_re_next);
  assign qy_s = AW'(q_im_next);
  assign dv_x = clip(neg_re ? -qx_s : qx_s);
  assign dv_y = clip(neg_im ? -qy_s : qy_s);

  assign bin_inc = out_bin + LOG2_BINS'(1);

  // Next-state and next-register values.
  always_comb begin
    state_n  = state;
    x1_n     = x1_r;
    y1_n     = y1_r;
    x2_n     = x2_r;
    y2_n     = y2_r;
    mode_n   = mode_r;
    re_n     = re_r;
    im_n     = im_r;
    mag_n    = mag_r;
    neg_re_n = neg_re;
    neg_im_n = neg_im;
    rem_re_n = rem_re;
    rem_im_n = rem_im;
    q_re_n   = q_re;
    q_im_n   = q_im;
    cnt_n    = cnt;
    xf_n     = xf;
    yf_n     = yf;
    sat_n    = out_sat;
    zero_n   = out_zero;
    bin_n    = out_bin;
    last_n   = out_last;
    case (state)
      IDLE: begin
        if (in_valid) begin
          x1_n    = x1;
          y1_n    = y1;
          x2_n    = x2;
          y2_n    = y2;
          mode_n  = mode;
          state_n = MUL;
        end
      end
      MUL: begin
        re_n = re_c;
        im_n = im_c;
        if (mode_r) begin
          state_n = MAG;
        end else begin
          xf_n    = sh_x[OW-1:0];
          yf_n    = sh_y[OW-1:0];
          sat_n   = sh_x[OW] | sh_y[OW];
          zero_n  = 1'b0;
          state_n = OUT;
        end
      end
      MAG: begin
        mag_n    = mag_c;
        neg_re_n = re_r[PW-1];
        neg_im_n = im_r[PW-1];
        if (mag_c == '0) begin
          xf_n    = '0;
          yf_n    = '0;
          sat_n   = 1'b0;
          zero_n  = 1'b1;
          state_n = OUT;
        end else begin
          rem_re_n = RW'(re_abs);
          rem_im_n = RW'(im_abs);
          q_re_n   = '0;
          q_im_n   = '0;
          cnt_n    = '0;
          state_n  = DIV;
        end
      end
      DIV: begin
        rem_re_n = rem_re_step << 1;
        rem_im_n = rem_im_step << 1;
        q_re_n   = q_re_next;
        q_im_n   = q_im_next;
        cnt_n    = cnt + CW'(1);
        if (cnt == CW'(FRAC)) begin
          xf_n    = dv_x[OW-1:0];
          yf_n    = dv_y[OW-1:0];
          sat_n   = dv_x[OW] | dv_y[OW];
          zero_n  = 1'b0;
          state_n = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          bin_n   = bin_inc;
          last_n  = &bin_inc;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    valid_n = (state_n == OUT);
    ready_n = (state_n == IDLE);
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      x1_r      <= '0;
      y1_r      <= '0;
      x2_r      <= '0;
      y2_r      <= '0;
      mode_r    <= 1'b0;
      re_r      <= '0;
      im_r      <= '0;
      mag_r     <= '0;
      neg_re    <= 1'b0;
      neg_im    <= 1'b0;
      rem_re    <= '0;
      rem_im    <= '0;
      q_re      <= '0;
      q_im      <= '0;
      cnt       <= '0;
      xf        <= '0;
      yf        <= '0;
      out_sat   <= 1'b0;
      out_zero  <= 1'b0;
      out_bin   <= '0;
      out_last  <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state     <= state_n;
      x1_r      <= x1_n;
      y1_r      <= y1_n;
      x2_r      <= x2_n;
      y2_r      <= y2_n;
      mode_r    <= mode_n;
      re_r      <= re_n;
      im_r      <= im_n;
      mag_r     <= mag_n;
      neg_re    <= neg_re_n;
      neg_im    <= neg_im_n;
      rem_re    <= rem_re_n;
      rem_im    <= rem_im_n;
      q_re      <= q_re_n;
      q_im      <= q_im_n;
      cnt       <= cnt_n;
      xf        <= xf_n;
      yf        <= yf_n;
      out_sat   <= sat_n;
      out_zero  <= zero_n;
      out_bin   <= bin_n;
      out_last  <= last_n;
      out_valid <= valid_n;
      in_ready  <= ready_n;
    end
  end

endmodule

// File: tb/tb_cps_normalizer.sv
// Bench for cps_normalizer: directed cases plus a randomized stream checked
// against an arithmetic reference model. A second instance uses SHIFT=4.
module tb_cps_normalizer;

  localparam int FRAC = 14;
  localparam int LB   = 10;
  localparam int NB   = 1 << LB;
  localparam int SH   = 18;
  localparam int SH4  = 4;
  localparam int NS   = NB + 6;

  typedef struct packed {
    logic signed [15:0] xf;
    logic signed [15:0] yf;
    logic               sat;
    logic               zero;
  } res_t;

  logic clk, rst, mode, in_valid, out_ready;
  logic signed [15:0] x1, y1, x2, y2;
  logic in_ready, out_valid, out_last, out_sat, out_zero;
  logic signed [15:0] xf, yf;
  logic [LB-1:0] out_bin;
  logic in_ready4, out_valid4, out_last4, out_sat4, out_zero4;
  logic signed [15:0] xf4, yf4;
  logic [LB-1:0] out_bin4;

  int n_checks = 0;
  int n_errors = 0;
  int exp_bin  = 0;

  cps_normalizer #(.W(16), .OW(16), .SHIFT(SH), .FRAC(FRAC), .LOG2_BINS(LB)) u_dut (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .x1(x1), .y1(y1), .x2(x2), .y2(y2), .out_valid(out_valid), .out_ready(out_ready),
    .xf(xf), .yf(yf), .out_bin(out_bin), .out_last(out_last), .out_sat(out_sat),
    .out_zero(out_zero)
  );

  cps_normalizer #(.W(16), .OW(16), .SHIFT(SH4), .FRAC(FRAC), .LOG2_BINS(LB)) u_dut4 (
    .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready4),
    .x1(x1), .y1(y1), .x2(x2), .y2(y2), .out_valid(out_valid4), .out_ready(out_ready),
    .xf(xf4), .yf(yf4), .out_bin(out_bin4), .out_last(out_last4), .out_sat(out_sat4),
    .out_zero(out_zero4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint iabs(input longint v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic longint floordiv(input longint a, input longint d);
    longint q;
    q = a / d;
    if ((a % d != 0) && (a < 0)) q = q - 1;
    return q;
  endfunction

  function automatic longint sat16(input longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  // Reference: cross product, then shift-floor or magnitude-normalise, then clip.
  function automatic res_t model(input bit m, input int a1, input int b1,
                                 input int a2, input int b2, input int sh);
    longint re, im, mag, qr, qi;
    res_t r;
    r  = '0;
    re = longint'(a1) * a2 + longint'(b1) * b2;
    im = longint'(b1) * a2 - longint'(a1) * b2;
    if (!m) begin
      qr = floordiv(re, longint'(1) << sh);
      qi = floordiv(im, longint'(1) << sh);
    end else begin
      mag = iabs(re) + iabs(im);
      if (mag == 0) begin
        r.zero = 1'b1;
        return r;
      end
      qr = (iabs(re) * (longint'(1) << FRAC)) / mag;
      qi = (iabs(im) * (longint'(1) << FRAC)) / mag;
      if (re < 0) qr = -qr;
      if (im < 0) qi = -qi;
    end
    r.sat = (sat16(qr) != qr) || (sat16(qi) != qi);
    r.xf  = 16'(sat16(qr));
    r.yf  = 16'(sat16(qi));
    return r;
  endfunction

  function automatic int rnd_comp();
    case ($urandom_range(0, 7))
      0:       return -32768;
      1:       return 32767;
      2:       return 0;
      3:       return int'($urandom_range(0, 16)) - 8;
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // One bin through both instances, with latency and handshake checks.
  task automatic run_one(input string tag, input bit m, input int a1, input int b1,
                         input int a2, input int b2, input int exp_lat);
    res_t e, e4;
    int lat;
    e  = model(m, a1, b1, a2, b2, SH);
    e4 = model(m, a1, b1, a2, b2, SH4);
    @(negedge clk);
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    check({tag, ".in_ready"}, in_ready, 1);
    mode = m; x1 = 16'(a1); y1 = 16'(b1); x2 = 16'(a2); y2 = 16'(b2);
    in_valid = 1'b1;
    @(posedge clk);
    lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        mode = ~m; x1 = 16'($urandom); y1 = 16'($urandom);
        x2 = 16'($urandom); y2 = 16'($urandom);
      end
      if (out_valid) break;
    end
    check({tag, ".latency"}, lat, exp_lat);
    check({tag, ".xf"}, xf, e.xf);
    check({tag, ".yf"}, yf, e.yf);
    check({tag, ".sat"}, out_sat, e.sat);
    check({tag, ".zero"}, out_zero, e.zero);
    check({tag, ".bin"}, out_bin, exp_bin);
    check({tag, ".last"}, out_last, (exp_bin == NB - 1) ? 1 : 0);
    check({tag, ".xf4"}, xf4, e4.xf);
    check({tag, ".yf4"}, yf4, e4.yf);
    check({tag, ".sat4"}, out_sat4, e4.sat);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, ".valid_after"}, out_valid, 0);
    check({tag, ".ready_after"}, in_ready, 1);
    out_ready = 1'b0;
    exp_bin = (exp_bin + 1) % NB;
  endtask

  initial begin
    res_t e, q[$];
    int sent, recv, cyc, a1, b1, a2, b2, lat;
    bit m, stalled;
    logic signed [15:0] hxf, hyf;
    logic [LB-1:0] hbin;
    logic hlast;

    rst = 1'b1; mode = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    x1 = '0; y1 = '0; x2 = '0; y2 = '0;
    repeat (3) @(negedge clk);
    check("rst.valid", out_valid, 0);
    check("rst.ready", in_ready, 1);
    check("rst.xf", xf, 0);
    check("rst.yf", yf, 0);
    check("rst.bin", out_bin, 0);
    check("rst.last", out_last, 0);
    check("rst.sat", out_sat, 0);
    check("rst.zero", out_zero, 0);
    rst = 1'b0;

    run_one("m0_pos", 1'b0, 1000, 0, 1000, 0, 2);
    run_one("m0_neg", 1'b0, -1000, 0, 1000, 0, 2);
    run_one("m1_a", 1'b1, 3, 4, 3, 0, FRAC + 4);
    run_one("m1_b", 1'b1, 100, 0, 0, 100, FRAC + 4);
    run_one("m1_zero", 1'b1, 0, 0, 0, 0, 3);
    run_one("m0_sat", 1'b0, 1000, 1000, 1000, 1000, 2);
    run_one("m1_corner", 1'b1, -32768, -32768, -32768, -32768, FRAC + 4);
    run_one("m0_corner", 1'b0, -32768, 32767, -32768, -32768, 2);
    for (int i = 0; i < 8; i++) begin
      m = 1'($urandom_range(0, 1));
      a1 = rnd_comp(); b1 = rnd_comp(); a2 = rnd_comp(); b2 = rnd_comp();
      e = model(m, a1, b1, a2, b2, SH);
      lat = !m ? 2 : (e.zero ? 3 : FRAC + 4);
      run_one("rand", m, a1, b1, a2, b2, lat);
    end

    // Reset while the divider is running.
    @(negedge clk);
    mode = 1'b1; x1 = 16'(3); y1 = 16'(4); x2 = 16'(3); y2 = 16'(0);
    in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("mid.busy", in_ready, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid.valid", out_valid, 0);
    check("mid.ready", in_ready, 1);
    check("mid.bin", out_bin, 0);
    check("mid.xf", xf, 0);
    exp_bin = 0;
    run_one("after_rst", 1'b1, 3, 4, 3, 0, FRAC + 4);

    // Randomized stream with random backpressure across a frame boundary.
    do_reset();
    exp_bin = 0; sent = 0; recv = 0; cyc = 0; stalled = 1'b0;
    hxf = '0; hyf = '0; hbin = '0; hlast = 1'b0;
    while (recv < NS && cyc < 60000) begin
      @(negedge clk);
      cyc++;
      if (out_valid) begin
        if (stalled) begin
          check("hold.xf", xf, hxf);
          check("hold.yf", yf, hyf);
          check("hold.bin", out_bin, hbin);
          check("hold.last", out_last, hlast);
        end
        if ($urandom_range(0, 2) != 0) begin
          check("stream.inflight", q.size(), 1);
          if (q.size() != 0) begin
            e = q.pop_front();
            check("stream.xf", xf, e.xf);
            check("stream.yf", yf, e.yf);
            check("stream.sat", out_sat, e.sat);
            check("stream.zero", out_zero, e.zero);
            check("stream.bin", out_bin, exp_bin);
            check("stream.last", out_last, (exp_bin == NB - 1) ? 1 : 0);
            exp_bin = (exp_bin + 1) % NB;
            recv++;
          end
          out_ready = 1'b1;
          stalled   = 1'b0;
        end else begin
          out_ready = 1'b0;
          stalled   = 1'b1;
          hxf = xf; hyf = yf; hbin = out_bin; hlast = out_last;
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
        stalled   = 1'b0;
      end
      if (in_ready && sent < NS && $urandom_range(0, 3) != 0) begin
        m = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 15) == 0) begin
          a1 = 0; b1 = 0; a2 = 0; b2 = 0;
        end else begin
          a1 = rnd_comp(); b1 = rnd_comp(); a2 = rnd_comp(); b2 = rnd_comp();
        end
        mode = m; x1 = 16'(a1); y1 = 16'(b1); x2 = 16'(a2); y2 = 16'(b2);
        in_valid = 1'b1;
        q.push_back(model(m, a1, b1, a2, b2, SH));
        sent++;
      end else begin
        in_valid = 1'b0;
        mode = 1'($urandom); x1 = 16'($urandom); y1 = 16'($urandom);
        x2 = 16'($urandom); y2 = 16'($urandom);
      end
    end
    check("stream.count", recv, NS);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cps_normalizer.md
# cps_normalizer

Sequential, parametrised cross-power-spectrum stage for the phase-correlation motion estimator. It sits between the two 2D forward FFTs and the inverse FFT. It takes one frequency bin per handshake: the complex bin of frame 1 and the complex bin of frame 2. For each bin it computes F1·conj(F2) and normalises the result, either by a constant power-of-two shift or by true L1-magnitude division. The output is one bin per handshake, with bin index, frame-last marker and status flags.

## Interface
- W, 16: signed width of each input component.
- OW, 16: signed width of each output component.
- SHIFT, 18: arithmetic right shift used in constant mode.
- FRAC, 14: fractional bits of the magnitude-mode output (unit magnitude = 2^FRAC).
- LOG2_BINS, 10: log2 of bins per frame (1024 = 32x32).
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- mode  in  1  0 = constant shift, 1 = magnitude normalise; sampled at input handshake.
- in_valid  in  1  input bin valid.
- in_ready  out  1  block can accept a bin.
- x1, y1  in  W each  frame-1 bin, real and imaginary, signed.
- x2, y2  in  W each  frame-2 bin, real and imaginary, signed.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- xf, yf  out  OW each  normalised CPS, real and imaginary, signed.
- out_bin  out  LOG2_BINS  index of the current output bin.
- out_last  out  1  high when out_bin = 2^LOG2_BINS−1.
- out_sat  out  1  xf or yf was clipped.
- out_zero  out  1  magnitude was zero (mode 1 only).

## Operation
- States: IDLE, MUL, MAG, DIV, OUT. One bin is in flight at a time. in_ready = (state==IDLE).
- IDLE: when in_valid, latch the inputs and mode, then go to MUL.
- MUL: compute the products, registered at full width 2W+1:
  - re = x1·x2 + y1·y2
  - im = y1·x2 − x1·y2
  - Next state is OUT in mode 0, MAG in mode 1.
- Mode 0 (MUL → OUT): xf = re >>> SHIFT, yf = im >>> SHIFT.
  - The shift is arithmetic, so it rounds toward −∞.
  - Each result saturates to [−2^(OW−1), 2^(OW−1)−1].
- MAG: compute mag = |re| + |im| (2W+2 bits) and register the signs.
  - If mag == 0: xf = yf = 0, out_zero = 1, go to OUT.
  - Otherwise: load the divider and go to DIV.
- DIV: two parallel restoring dividers compute |re|·2^FRAC / mag and |im|·2^FRAC / mag.
  - One quotient bit per cycle, MSB first, FRAC+1 cycles.
  - Quotients truncate toward zero. Each quotient lies in [0, 2^FRAC].
  - Apply the registered sign, saturate to OW, then go to OUT.
- OUT: hold out_valid and all output fields stable until out_ready.
  - On handshake: go to IDLE.
  - The bin counter increments, wrapping from 2^LOG2_BINS−1 to 0.
- out_sat is set if either component was clipped. It and out_zero are per-result, not sticky.

## Timing
- Reset values: state IDLE, out_valid 0, in_ready 1, xf 0, yf 0, out_bin 0, out_last 0, out_sat 0, out_zero 0.
- Latency from the input handshake edge T to the first cycle with out_valid:
  - mode 0: 2 cycles.
  - mode 1, nonzero magnitude: FRAC+4 cycles (18 with defaults).
  - mode 1, zero magnitude: 3 cycles.
- Throughput with out_ready held high:
  - mode 0: 1 bin per 3 cycles.
  - mode 1: 1 bin per FRAC+5 cycles.
- in_ready is low from the cycle after acceptance until the cycle after the output handshake.
  - A new input can therefore never be accepted in the same cycle as an output handshake.
- Inputs are ignored while in_ready = 0. mode changes take effect only at the next acceptance.
- rst in any state aborts the in-flight bin. The next cycle shows reset values and the bin counter is 0.
- out_last and out_bin stay stable while out_valid holds under backpressure.

## Test plan
- Mode 0, x1=1000, y1=0, x2=1000, y2=0 → xf=3 (1,000,000>>>18), yf=0, out_valid 2 cycles after accept, out_sat=0.
- Mode 0, x1=−1000, y1=0, x2=1000, y2=0 → xf=−4 (floor rounding), yf=0.
- Mode 1, two cases, each with out_valid 18 cycles after accept:
  - x1=3, y1=4, x2=3, y2=0 → re=9, im=12, mag=21 → xf=7021, yf=9362.
  - x1=100, y1=0, x2=0, y2=100 → xf=0, yf=−16384.
- Mode 1, all inputs 0 → xf=yf=0, out_zero=1, latency 3. Instance with SHIFT=4, mode 0, all inputs 1000 → xf=32767, yf=0, out_sat=1.
- Stream 1024 random bins with out_ready toggling pseudo-randomly → outputs match the golden model in order, outputs stay stable while stalled, out_last only on bin 1023, out_bin wraps to 0 on the next frame.
- Assert rst for one cycle mid-DIV → next cycle out_valid=0, in_ready=1, out_bin=0. The next accepted bin completes with mode-1 latency 18.
